// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with arbitrary depth and show-ahead read.
// It has programmable almost-full/almost-empty watermarks, a fill level,
// a synchronous flush, and overflow/underflow reporting.
// Build option: define SYNC_FIFO_PROG_STICKY_ERR_EN to make the error flags
// sticky until err_clr. Without it they are one-cycle pulses.
module sync_fifo_prog #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] data_push,
    input  logic             pop,
    output logic [WIDTH-1:0] data_pop,
    input  logic [CW-1:0]    af_thresh,
    input  logic [CW-1:0]    ae_thresh,
    output logic [CW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_ok, pop_ok, ovf_evt, udf_evt;

    // Pointer wrap that does not rely on DEPTH being a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Status is a pure decode of the registered count.
    assign level        = cnt;
    assign full         = (cnt == CW'(DEPTH));
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= af_thresh);
    assign almost_empty = (cnt <= ae_thresh);
    assign data_pop     = empty ? '0 : mem[rd_ptr];

    // A pop in the same cycle frees a slot, so a push on full is still taken.
    // Flush suppresses both transfers and any error report.
    assign push_ok = push & (~full | pop) & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;
    assign ovf_evt = push & full & ~pop & ~flush;
    assign udf_evt = pop & empty & ~flush;

    // Pointers and occupancy count. Priority is reset, then flush, then traffic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage write. The storage is never cleared, and only the pointers define the contents.
    always_ff @(posedge clk) begin
        if (rst && push_ok) mem[wr_ptr] <= data_push;
    end

`ifdef SYNC_FIFO_PROG_STICKY_ERR_EN
    // Sticky error flags. A clear request beats a same-cycle error event.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) overflow  <= 1'b1;
            if (udf_evt) underflow <= 1'b1;
        end
    end
`else
    // One-cycle error pulses, registered from the event cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_evt;
            underflow <= udf_evt;
        end
    end

    // err_clr has no function when the flags are pulses.
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

endmodule
